// File: rtl/vy_hakem.sv
// vy_hakem: round-robin arbiter sharing the vy_denetleyici block channel
// between the L1 instruction cache (port B) and L1 data cache (port V).
module vy_hakem #(
   parameter int ADRES_BIT = 32,
   parameter int BLOK_BIT  = 128
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic [ADRES_BIT-1:0] l1b_istek_adres_i,
   input  logic [BLOK_BIT-1:0]  l1b_istek_veri_i,
   input  logic                 l1b_istek_yaz_i,
   input  logic                 l1b_istek_gecerli_i,
   output logic                 l1b_istek_hazir_o,
   output logic [BLOK_BIT-1:0]  l1b_veri_o,
   output logic                 l1b_veri_gecerli_o,
   input  logic                 l1b_veri_hazir_i,

   input  logic [ADRES_BIT-1:0] l1v_istek_adres_i,
   input  logic [BLOK_BIT-1:0]  l1v_istek_veri_i,
   input  logic                 l1v_istek_yaz_i,
   input  logic                 l1v_istek_gecerli_i,
   output logic                 l1v_istek_hazir_o,
   output logic [BLOK_BIT-1:0]  l1v_veri_o,
   output logic                 l1v_veri_gecerli_o,
   input  logic                 l1v_veri_hazir_i,

   output logic [ADRES_BIT-1:0] vy_istek_adres_o,
   output logic [BLOK_BIT-1:0]  vy_istek_veri_o,
   output logic                 vy_istek_yaz_o,
   output logic                 vy_istek_gecerli_o,
   input  logic                 vy_istek_hazir_i,
   input  logic [BLOK_BIT-1:0]  vy_veri_i,
   input  logic                 vy_veri_gecerli_i,
   output logic                 vy_veri_hazir_o
);

   typedef enum logic [1:0] {
      BOSTA,
      ISTEK,
      YANIT
   } durum_t;

   localparam logic PORT_B = 1'b0;
   localparam logic PORT_V = 1'b1;

   durum_t                durum_q, durum_d;
   logic                  sahip_q, sahip_d;
   logic                  son_q, son_d;
   logic [ADRES_BIT-1:0]  adres_q, adres_d;
   logic [BLOK_BIT-1:0]   veri_q, veri_d;
   logic                  yaz_q, yaz_d;
   logic                  gecerli_q, gecerli_d;

   logic                  bosta;
   logic                  yanit;
   logic                  b_hazir;
   logic                  v_hazir;
   logic                  b_el;
   logic                  v_el;
   logic                  sahip_hazir;

   // Grant eligibility and handshake detection; last winner yields ties.
   always_comb begin
      bosta       = (durum_q == BOSTA) && !rst_i;
      yanit       = (durum_q == YANIT) && !rst_i;
      b_hazir     = bosta &&
                    (!l1v_istek_gecerli_i || son_q == PORT_V);
      v_hazir     = bosta &&
                    (!l1b_istek_gecerli_i || son_q == PORT_B);
      b_el        = l1b_istek_gecerli_i && b_hazir;
      v_el        = l1v_istek_gecerli_i && v_hazir;
      sahip_hazir = (sahip_q == PORT_V) ? l1v_veri_hazir_i
                                        : l1b_veri_hazir_i;
   end

   // State and request registers; reset leaves B favoured for first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q   <= BOSTA;
         sahip_q   <= PORT_B;
         son_q     <= PORT_V;
         adres_q   <= '0;
         veri_q    <= '0;
         yaz_q     <= 1'b0;
         gecerli_q <= 1'b0;
      end else begin
         durum_q   <= durum_d;
         sahip_q   <= sahip_d;
         son_q     <= son_d;
         adres_q   <= adres_d;
         veri_q    <= veri_d;
         yaz_q     <= yaz_d;
         gecerli_q <= gecerli_d;
      end
   end

   // Next-state logic: grant, forward downstream, then await the block.
   always_comb begin
      durum_d   = durum_q;
      sahip_d   = sahip_q;
      son_d     = son_q;
      adres_d   = adres_q;
      veri_d    = veri_q;
      yaz_d     = yaz_q;
      gecerli_d = gecerli_q;
      unique case (durum_q)
         BOSTA: begin
            if (b_el) begin
               adres_d   = l1b_istek_adres_i;
               veri_d    = l1b_istek_veri_i;
               yaz_d     = l1b_istek_yaz_i;
               gecerli_d = 1'b1;
               sahip_d   = PORT_B;
               son_d     = PORT_B;
               durum_d   = ISTEK;
            end else if (v_el) begin
               adres_d   = l1v_istek_adres_i;
               veri_d    = l1v_istek_veri_i;
               yaz_d     = l1v_istek_yaz_i;
               gecerli_d = 1'b1;
               sahip_d   = PORT_V;
               son_d     = PORT_V;
               durum_d   = ISTEK;
            end
         end
         ISTEK: begin
            if (gecerli_q && vy_istek_hazir_i) begin
               gecerli_d = 1'b0;
               durum_d   = yaz_q ? BOSTA : YANIT;
            end
         end
         YANIT: begin
            if (vy_veri_gecerli_i && sahip_hazir) begin
               durum_d = BOSTA;
            end
         end
         default: begin
            durum_d   = BOSTA;
            gecerli_d = 1'b0;
         end
      endcase
   end

   // Output steering: requests from registers, responses to the owner only.
   always_comb begin
      l1b_istek_hazir_o  = b_hazir;
      l1v_istek_hazir_o  = v_hazir;
      vy_istek_adres_o   = adres_q;
      vy_istek_veri_o    = veri_q;
      vy_istek_yaz_o     = yaz_q;
      vy_istek_gecerli_o = gecerli_q;
      l1b_veri_o         = '0;
      l1v_veri_o         = '0;
      l1b_veri_gecerli_o = 1'b0;
      l1v_veri_gecerli_o = 1'b0;
      vy_veri_hazir_o    = 1'b0;
      if (yanit) begin
         vy_veri_hazir_o = sahip_hazir;
         if (sahip_q == PORT_V) begin
            l1v_veri_o         = vy_veri_i;
            l1v_veri_gecerli_o = vy_veri_gecerli_i;
         end else begin
            l1b_veri_o         = vy_veri_i;
            l1b_veri_gecerli_o = vy_veri_gecerli_i;
         end
      end
   end

endmodule

// File: tb/tb_vy_hakem.sv
// tb_vy_hakem: directed scenario bench for the vy_hakem arbiter.
// Each task drives one scenario and checks hand-computed values.
module tb_vy_hakem;

   localparam int AB = 32;
   localparam int BB = 128;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [AB-1:0] l1b_istek_adres_i;
   logic [BB-1:0] l1b_istek_veri_i;
   logic          l1b_istek_yaz_i;
   logic          l1b_istek_gecerli_i;
   logic          l1b_istek_hazir_o;
   logic [BB-1:0] l1b_veri_o;
   logic          l1b_veri_gecerli_o;
   logic          l1b_veri_hazir_i;
   logic [AB-1:0] l1v_istek_adres_i;
   logic [BB-1:0] l1v_istek_veri_i;
   logic          l1v_istek_yaz_i;
   logic          l1v_istek_gecerli_i;
   logic          l1v_istek_hazir_o;
   logic [BB-1:0] l1v_veri_o;
   logic          l1v_veri_gecerli_o;
   logic          l1v_veri_hazir_i;
   logic [AB-1:0] vy_istek_adres_o;
   logic [BB-1:0] vy_istek_veri_o;
   logic          vy_istek_yaz_o;
   logic          vy_istek_gecerli_o;
   logic          vy_istek_hazir_i;
   logic [BB-1:0] vy_veri_i;
   logic          vy_veri_gecerli_i;
   logic          vy_veri_hazir_o;

   int checks = 0;
   int errors = 0;

   vy_hakem #(.ADRES_BIT(AB), .BLOK_BIT(BB)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .l1b_istek_adres_i   (l1b_istek_adres_i),
      .l1b_istek_veri_i    (l1b_istek_veri_i),
      .l1b_istek_yaz_i     (l1b_istek_yaz_i),
      .l1b_istek_gecerli_i (l1b_istek_gecerli_i),
      .l1b_istek_hazir_o   (l1b_istek_hazir_o),
      .l1b_veri_o          (l1b_veri_o),
      .l1b_veri_gecerli_o  (l1b_veri_gecerli_o),
      .l1b_veri_hazir_i    (l1b_veri_hazir_i),
      .l1v_istek_adres_i   (l1v_istek_adres_i),
      .l1v_istek_veri_i    (l1v_istek_veri_i),
      .l1v_istek_yaz_i     (l1v_istek_yaz_i),
      .l1v_istek_gecerli_i (l1v_istek_gecerli_i),
      .l1v_istek_hazir_o   (l1v_istek_hazir_o),
      .l1v_veri_o          (l1v_veri_o),
      .l1v_veri_gecerli_o  (l1v_veri_gecerli_o),
      .l1v_veri_hazir_i    (l1v_veri_hazir_i),
      .vy_istek_adres_o    (vy_istek_adres_o),
      .vy_istek_veri_o     (vy_istek_veri_o),
      .vy_istek_yaz_o      (vy_istek_yaz_o),
      .vy_istek_gecerli_o  (vy_istek_gecerli_o),
      .vy_istek_hazir_i    (vy_istek_hazir_i),
      .vy_veri_i           (vy_veri_i),
      .vy_veri_gecerli_i   (vy_veri_gecerli_i),
      .vy_veri_hazir_o     (vy_veri_hazir_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs;
      l1b_istek_adres_i   = '0;
      l1b_istek_veri_i    = '0;
      l1b_istek_yaz_i     = 1'b0;
      l1b_istek_gecerli_i = 1'b0;
      l1b_veri_hazir_i    = 1'b0;
      l1v_istek_adres_i   = '0;
      l1v_istek_veri_i    = '0;
      l1v_istek_yaz_i     = 1'b0;
      l1v_istek_gecerli_i = 1'b0;
      l1v_veri_hazir_i    = 1'b0;
      vy_istek_hazir_i    = 1'b0;
      vy_veri_i           = '0;
      vy_veri_gecerli_i   = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_i = 1'b1;
      tick();
      tick();
      checks++;
      if (l1b_istek_hazir_o !== 1'b0 || l1v_istek_hazir_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_hazir: got b=%b v=%b expected 0 0",
                  l1b_istek_hazir_o, l1v_istek_hazir_o);
      end
      checks++;
      if (vy_istek_gecerli_o !== 1'b0 || vy_istek_adres_o !== '0 ||
          vy_istek_yaz_o !== 1'b0 || vy_istek_veri_o !== '0) begin
         errors++;
         $display("FAIL rst_istek: got g=%b a=%h y=%b expected zeros",
                  vy_istek_gecerli_o, vy_istek_adres_o, vy_istek_yaz_o);
      end
      rst_i = 1'b0;
      #1;
      checks++;
      if (l1b_istek_hazir_o !== 1'b1 || l1v_istek_hazir_o !== 1'b1) begin
         errors++;
         $display("FAIL idle_hazir: got b=%b v=%b expected 1 1",
                  l1b_istek_hazir_o, l1v_istek_hazir_o);
      end
   endtask

   task automatic test_b_read;
      logic [BB-1:0] blk;
      blk = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      l1b_istek_adres_i   = 32'h0000_1000;
      l1b_istek_yaz_i     = 1'b0;
      l1b_istek_gecerli_i = 1'b1;
      l1b_veri_hazir_i    = 1'b1;
      vy_istek_hazir_i    = 1'b1;
      #1;
      checks++;
      if (l1b_istek_hazir_o !== 1'b1) begin
         errors++;
         $display("FAIL rd_b_hazir: got %b expected 1", l1b_istek_hazir_o);
      end
      tick();
      l1b_istek_gecerli_i = 1'b0;
      #1;
      checks++;
      if (vy_istek_gecerli_o !== 1'b1 || vy_istek_adres_o !== 32'h1000 ||
          vy_istek_yaz_o !== 1'b0) begin
         errors++;
         $display("FAIL rd_istek: got g=%b a=%h y=%b expected 1 1000 0",
                  vy_istek_gecerli_o, vy_istek_adres_o, vy_istek_yaz_o);
      end
      tick();
      checks++;
      if (vy_istek_gecerli_o !== 1'b0) begin
         errors++;
         $display("FAIL rd_istek_1cyc: got %b expected 0", vy_istek_gecerli_o);
      end
      repeat (5) tick();
      checks++;
      if (l1b_veri_gecerli_o !== 1'b0) begin
         errors++;
         $display("FAIL rd_early_gec: got %b expected 0", l1b_veri_gecerli_o);
      end
      vy_veri_i         = blk;
      vy_veri_gecerli_i = 1'b1;
      #1;
      checks++;
      if (l1b_veri_o !== blk || l1b_veri_gecerli_o !== 1'b1) begin
         errors++;
         $display("FAIL rd_yanit: got g=%b d=%h expected 1 %h",
                  l1b_veri_gecerli_o, l1b_veri_o, blk);
      end
      checks++;
      if (l1v_veri_gecerli_o !== 1'b0 || vy_veri_hazir_o !== 1'b1) begin
         errors++;
         $display("FAIL rd_route: got vg=%b vh=%b expected 0 1",
                  l1v_veri_gecerli_o, vy_veri_hazir_o);
      end
      tick();
      vy_veri_gecerli_i = 1'b0;
      #1;
      checks++;
      if (l1b_veri_gecerli_o !== 1'b0 || l1b_istek_hazir_o !== 1'b1) begin
         errors++;
         $display("FAIL rd_done: got g=%b h=%b expected 0 1",
                  l1b_veri_gecerli_o, l1b_istek_hazir_o);
      end
      idle_inputs();
   endtask

   task automatic test_round_robin;
      logic [AB-1:0] exp_a;
      logic [BB-1:0] exp_d;
      test_reset();
      l1b_istek_adres_i   = 32'h100;
      l1v_istek_adres_i   = 32'h200;
      l1b_istek_gecerli_i = 1'b1;
      l1v_istek_gecerli_i = 1'b1;
      l1b_veri_hazir_i    = 1'b1;
      l1v_veri_hazir_i    = 1'b1;
      vy_istek_hazir_i    = 1'b1;
      for (int g = 0; g < 4; g++) begin
         exp_a = (g % 2 == 1) ? 32'h200 : 32'h100;
         exp_d = {4{exp_a}};
         tick();
         checks++;
         if (vy_istek_gecerli_o !== 1'b1 || vy_istek_adres_o !== exp_a) begin
            errors++;
            $display("FAIL rr_grant%0d: got g=%b a=%h expected 1 %h",
                     g, vy_istek_gecerli_o, vy_istek_adres_o, exp_a);
         end
         tick();
         vy_veri_i         = exp_d;
         vy_veri_gecerli_i = 1'b1;
         #1;
         checks++;
         if (g % 2 == 0) begin
            if (l1b_veri_gecerli_o !== 1'b1 || l1b_veri_o !== exp_d ||
                l1v_veri_gecerli_o !== 1'b0) begin
               errors++;
               $display("FAIL rr_resp%0d: got bg=%b vg=%b expected 1 0",
                        g, l1b_veri_gecerli_o, l1v_veri_gecerli_o);
            end
         end else begin
            if (l1v_veri_gecerli_o !== 1'b1 || l1v_veri_o !== exp_d ||
                l1b_veri_gecerli_o !== 1'b0) begin
               errors++;
               $display("FAIL rr_resp%0d: got bg=%b vg=%b expected 0 1",
                        g, l1b_veri_gecerli_o, l1v_veri_gecerli_o);
            end
         end
         tick();
         vy_veri_gecerli_i = 1'b0;
         #1;
      end
      idle_inputs();
   endtask

   task automatic test_v_write;
      logic [BB-1:0] blk;
      blk = {16{8'hAA}};
      l1v_istek_adres_i   = 32'h40;
      l1v_istek_veri_i    = blk;
      l1v_istek_yaz_i     = 1'b1;
      l1v_istek_gecerli_i = 1'b1;
      vy_istek_hazir_i    = 1'b0;
      #1;
      checks++;
      if (l1v_istek_hazir_o !== 1'b1) begin
         errors++;
         $display("FAIL wr_v_hazir: got %b expected 1", l1v_istek_hazir_o);
      end
      tick();
      l1v_istek_gecerli_i = 1'b0;
      l1v_istek_adres_i   = 32'hDEAD;
      l1v_istek_veri_i    = '0;
      l1v_istek_yaz_i     = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) vy_istek_hazir_i = 1'b1;
         #1;
         checks++;
         if (vy_istek_gecerli_o !== 1'b1 || vy_istek_adres_o !== 32'h40 ||
             vy_istek_veri_o !== blk || vy_istek_yaz_o !== 1'b1 ||
             l1b_veri_gecerli_o !== 1'b0 || l1v_veri_gecerli_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_hold%0d: got g=%b a=%h y=%b expected 1 40 1",
                     c, vy_istek_gecerli_o, vy_istek_adres_o, vy_istek_yaz_o);
         end
         tick();
      end
      vy_istek_hazir_i = 1'b0;
      #1;
      checks++;
      if (vy_istek_gecerli_o !== 1'b0 || l1b_istek_hazir_o !== 1'b1 ||
          l1v_istek_hazir_o !== 1'b1) begin
         errors++;
         $display("FAIL wr_release: got g=%b bh=%b vh=%b expected 0 1 1",
                  vy_istek_gecerli_o, l1b_istek_hazir_o, l1v_istek_hazir_o);
      end
      idle_inputs();
   endtask

   task automatic test_backpressure;
      logic [BB-1:0] blk;
      blk = 128'hFEED_0000_1111_2222_3333_4444_5555_6666;
      l1b_istek_adres_i   = 32'h2000;
      l1b_istek_gecerli_i = 1'b1;
      vy_istek_hazir_i    = 1'b1;
      l1b_veri_hazir_i    = 1'b0;
      tick();
      l1b_istek_gecerli_i = 1'b0;
      tick();
      vy_veri_i         = blk;
      vy_veri_gecerli_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (vy_veri_hazir_o !== 1'b0 || l1b_veri_gecerli_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall%0d: got h=%b g=%b expected 0 1",
                     c, vy_veri_hazir_o, l1b_veri_gecerli_o);
         end
         tick();
      end
      l1b_veri_hazir_i = 1'b1;
      #1;
      checks++;
      if (vy_veri_hazir_o !== 1'b1 || l1b_veri_o !== blk) begin
         errors++;
         $display("FAIL bp_go: got h=%b d=%h expected 1 %h",
                  vy_veri_hazir_o, l1b_veri_o, blk);
      end
      tick();
      vy_veri_gecerli_i = 1'b0;
      l1b_veri_hazir_i  = 1'b0;
      #1;
      checks++;
      if (l1b_istek_hazir_o !== 1'b1 || l1b_veri_gecerli_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_done: got h=%b g=%b expected 1 0",
                  l1b_istek_hazir_o, l1b_veri_gecerli_o);
      end
      idle_inputs();
   endtask

   task automatic test_async_reset;
      l1b_istek_adres_i   = 32'h3000;
      l1b_istek_gecerli_i = 1'b1;
      vy_istek_hazir_i    = 1'b1;
      l1b_veri_hazir_i    = 1'b0;
      tick();
      l1b_istek_gecerli_i = 1'b0;
      tick();
      vy_veri_i         = {4{32'h5A5A_A5A5}};
      vy_veri_gecerli_i = 1'b1;
      #1;
      checks++;
      if (l1b_veri_gecerli_o !== 1'b1) begin
         errors++;
         $display("FAIL ar_pre: got %b expected 1", l1b_veri_gecerli_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      checks++;
      if (l1b_veri_gecerli_o !== 1'b0 || l1v_veri_gecerli_o !== 1'b0 ||
          l1b_veri_o !== '0 || vy_veri_hazir_o !== 1'b0 ||
          l1b_istek_hazir_o !== 1'b0 || l1v_istek_hazir_o !== 1'b0 ||
          vy_istek_gecerli_o !== 1'b0 || vy_istek_adres_o !== '0) begin
         errors++;
         $display("FAIL ar_clear: got bg=%b bh=%b a=%h expected 0 0 0",
                  l1b_veri_gecerli_o, l1b_istek_hazir_o, vy_istek_adres_o);
      end
      #3;
      rst_i               = 1'b0;
      vy_veri_gecerli_i   = 1'b0;
      l1b_istek_adres_i   = 32'h300;
      l1v_istek_adres_i   = 32'h400;
      l1b_istek_gecerli_i = 1'b1;
      l1v_istek_gecerli_i = 1'b1;
      #1;
      checks++;
      if (l1b_istek_hazir_o !== 1'b1 || l1v_istek_hazir_o !== 1'b0) begin
         errors++;
         $display("FAIL ar_tie: got b=%b v=%b expected 1 0",
                  l1b_istek_hazir_o, l1v_istek_hazir_o);
      end
      tick();
      checks++;
      if (vy_istek_adres_o !== 32'h300 || vy_istek_gecerli_o !== 1'b1) begin
         errors++;
         $display("FAIL ar_grant: got a=%h g=%b expected 300 1",
                  vy_istek_adres_o, vy_istek_gecerli_o);
      end
      idle_inputs();
   endtask

   task automatic test_stray;
      test_reset();
      l1b_veri_hazir_i  = 1'b1;
      l1v_veri_hazir_i  = 1'b1;
      vy_veri_i         = {4{32'hCAFE_F00D}};
      vy_veri_gecerli_i = 1'b1;
      #1;
      checks++;
      if (l1b_veri_gecerli_o !== 1'b0 || l1v_veri_gecerli_o !== 1'b0 ||
          vy_veri_hazir_o !== 1'b0 || l1b_veri_o !== '0 ||
          l1v_veri_o !== '0) begin
         errors++;
         $display("FAIL stray: got bg=%b vg=%b h=%b expected 0 0 0",
                  l1b_veri_gecerli_o, l1v_veri_gecerli_o, vy_veri_hazir_o);
      end
      tick();
      checks++;
      if (l1b_istek_hazir_o !== 1'b1 || l1v_istek_hazir_o !== 1'b1) begin
         errors++;
         $display("FAIL stray_state: got b=%b v=%b expected 1 1",
                  l1b_istek_hazir_o, l1v_istek_hazir_o);
      end
      idle_inputs();
   endtask

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      test_reset();
      test_b_read();
      test_round_robin();
      test_v_write();
      test_backpressure();
      test_async_reset();
      test_stray();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
